// File: rtl/apb_arb_master.sv
// Two-requester APB master with round-robin arbitration.
// Registered APB outputs, wait-state timeout, one-cycle done pulses.
module apb_arb_master #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic [1:0]  req,
  input  logic [1:0]  req_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req0_wdata,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req0_strb,
  input  logic [3:0]  req1_strb,
  output logic [1:0]  done,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam logic [7:0] TO8 = 8'(TIMEOUT_CYC);
  localparam logic [8:0] TO9 = 9'(TIMEOUT_CYC);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  elig;
  logic        gnt_any;
  logic        gnt_id;
  logic        last_q;
  logic        gid_q;
  logic [7:0]  wcnt;
  logic        to_hit;
  logic        psel_d;
  logic        penable_d;
  logic [1:0]  done_d;
  logic [31:0] rdata_d;
  logic        err_d;
  logic        to_d;

  // The requester currently signalled done sits out this arbitration
  assign elig    = req & ~done;
  assign gnt_any = |elig;

  // This ACCESS cycle would be the last one allowed with pready low
  assign to_hit = (state == ACCESS) && !pready &&
                  (({1'b0, wcnt} + 9'd1) >= TO9);

  // Round-robin pick: on a tie the requester not granted last wins
  always_comb begin
    gnt_id = 1'b0;
    unique case (elig)
      2'b11:   gnt_id = ~last_q;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= IDLE;
    else           state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt_any) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (pready || to_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode, registered below so every output is a flop
  always_comb begin
    psel_d    = (state_nx != IDLE);
    penable_d = (state_nx == ACCESS);
    done_d    = '0;
    rdata_d   = '0;
    err_d     = 1'b0;
    to_d      = 1'b0;
    if (state == ACCESS) begin
      if (pready) begin
        done_d[gid_q] = 1'b1;
        rdata_d       = pwrite ? '0 : prdata;
        err_d         = pslverr;
      end else if (to_hit) begin
        done_d[gid_q] = 1'b1;
        err_d         = 1'b1;
        to_d          = 1'b1;
      end
    end
  end

  // Control and response registers
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      psel        <= 1'b0;
      penable     <= 1'b0;
      done        <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      psel        <= psel_d;
      penable     <= penable_d;
      done        <= done_d;
      rsp_rdata   <= rdata_d;
      rsp_err     <= err_d;
      rsp_timeout <= to_d;
    end
  end

  // Latch the winner's request on the grant edge; hold otherwise
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      paddr  <= '0;
      pwdata <= '0;
      pstrb  <= '0;
      pwrite <= 1'b0;
      last_q <= 1'b1;
      gid_q  <= 1'b0;
    end else if (state == IDLE && gnt_any) begin
      paddr  <= gnt_id ? req1_addr  : req0_addr;
      pwdata <= gnt_id ? req1_wdata : req0_wdata;
      pstrb  <= gnt_id ? req1_strb  : req0_strb;
      pwrite <= req_write[gnt_id];
      last_q <= gnt_id;
      gid_q  <= gnt_id;
    end
  end

  // Wait counter: cleared leaving SETUP, counts pready-low ACCESS cycles
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wcnt <= '0;
    end else if (state == SETUP) begin
      wcnt <= '0;
    end else if (state == ACCESS && !pready && wcnt < TO8) begin
      wcnt <= wcnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: directed scenarios then random traffic
// checked against a transaction-level arbitration/response model.
module tb_apb_arb_master;

  localparam int TO = 16;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  req_write = '0;
  logic [31:0] req0_addr = '0;
  logic [31:0] req1_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic [31:0] req1_wdata = '0;
  logic [3:0]  req0_strb = '0;
  logic [3:0]  req1_strb = '0;
  logic [1:0]  done;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  apb_arb_master #(.TIMEOUT_CYC(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req(req), .req_write(req_write),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .req0_strb(req0_strb), .req1_strb(req1_strb),
    .done(done), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;

  // model state
  int          last_g = 1;
  int          mdone = -1;
  logic        sh_write [2];
  logic [31:0] sh_addr [2];
  logic [31:0] sh_wdata [2];
  logic [3:0]  sh_strb [2];
  logic        e_write;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic [3:0]  e_strb;

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    sh_write[i] = w; sh_addr[i] = a; sh_wdata[i] = d; sh_strb[i] = s;
    req_write[i] = w;
    if (i == 0) begin
      req0_addr = a; req0_wdata = d; req0_strb = s;
    end else begin
      req1_addr = a; req1_wdata = d; req1_strb = s;
    end
    req[i] = 1'b1;
  endtask

  // Spec rule: masked requester excluded; tie goes to the one not granted last
  function automatic int predict(logic [1:0] r, int masked, int last);
    logic [1:0] el;
    el = r;
    if (masked >= 0) el[masked] = 1'b0;
    if (el == 2'b11) return 1 - last;
    if (el[0]) return 0;
    if (el[1]) return 1;
    return -1;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_psel"}, 32'(psel), 32'd0);
    chk({tag, "_pen"}, 32'(penable), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_paddr"}, paddr, 32'd0);
    chk({tag, "_misc"},
        {pwdata[27:0], pstrb} | 32'(pwrite) | 32'(rsp_err) |
        32'(rsp_timeout) | rsp_rdata, 32'd0);
  endtask

  task automatic do_reset();
    preset_n = 1'b0;
    #1;
    chk_reset_vals("rst");
    tick();
    preset_n = 1'b1;
    last_g = 1;
    mdone = -1;
  endtask

  // Called at the negedge of an IDLE cycle; runs one grant opportunity
  task automatic grant_step(input int waits, input logic err,
                            input logic [31:0] rd, input bit keep);
    int w;
    bit fin;
    logic [31:0] exp_rd;
    w = predict(req, mdone, last_g);
    tick();
    if (!keep && mdone >= 0) req[mdone] = 1'b0;
    mdone = -1;
    if (w < 0) begin
      chk("idle_psel", 32'(psel), 32'd0);
      return;
    end
    last_g = w;
    e_write = sh_write[w]; e_addr = sh_addr[w];
    e_wdata = sh_wdata[w]; e_strb = sh_strb[w];
    chk("setup_psel", 32'(psel), 32'd1);
    chk("setup_pen", 32'(penable), 32'd0);
    chk("setup_paddr", paddr, e_addr);
    chk("setup_pwrite", 32'(pwrite), 32'(e_write));
    chk("setup_pwdata", pwdata, e_wdata);
    chk("setup_pstrb", 32'(pstrb), 32'(e_strb));
    chk("setup_done", 32'(done), 32'd0);
    // requester inputs are don't-care after the grant
    set_req(w, 1'($urandom), $urandom, $urandom, 4'($urandom));
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    tick();
    fin = 0;
    for (int i = 0; i < TO && !fin; i++) begin
      chk("acc_psel_pen", {30'd0, psel, penable}, 32'd3);
      chk("acc_paddr", paddr, e_addr);
      chk("acc_pwdata", pwdata, e_wdata);
      chk("acc_done", 32'(done), 32'd0);
      if (i >= waits) begin
        pready = 1'b1; pslverr = err; prdata = rd;
      end else begin
        pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
      end
      tick();
      if (i >= waits) begin
        fin = 1;
        exp_rd = e_write ? 32'd0 : rd;
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", 32'(rsp_err), 32'(err));
        chk("rsp_to", 32'(rsp_timeout), 32'd0);
      end else if (i == TO - 1) begin
        fin = 1;
        chk("to_rdata", rsp_rdata, 32'd0);
        chk("to_err_to", {30'd0, rsp_err, rsp_timeout}, 32'd3);
      end
    end
    chk("done_bit", 32'(done), 32'(1 << w));
    chk("done_bus_idle", {30'd0, psel, penable}, 32'd0);
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    mdone = w;
  endtask

  int order [4] = '{0, 1, 0, 1};
  int wt;

  initial begin
    sh_write[0] = 0; sh_write[1] = 0;
    sh_addr[0] = 0; sh_addr[1] = 0;
    sh_wdata[0] = 0; sh_wdata[1] = 0;
    sh_strb[0] = 0; sh_strb[1] = 0;
    tick();
    tick();
    do_reset();

    // single write with zero wait states
    set_req(0, 1'b1, 32'h10, 32'hA5, 4'hF);
    grant_step(0, 1'b0, 32'hDEAD_BEEF, 0);

    // read with 3 wait states
    set_req(1, 1'b0, 32'h40, 32'h0, 4'h0);
    grant_step(3, 1'b0, 32'h0000_1234, 0);
    chk("rd_1234", rsp_rdata, 32'h0000_1234);

    // both requesters held across four transfers after reset
    grant_step(0, 1'b0, 32'h0, 0);
    do_reset();
    set_req(0, 1'b1, 32'h100, 32'h11, 4'h3);
    set_req(1, 1'b0, 32'h200, 32'h22, 4'hC);
    for (int t = 0; t < 4; t++) begin
      grant_step(t % 2, 1'b0, $urandom, 1);
      chk("rr_order", 32'(done), 32'(1 << order[t]));
    end
    req = '0;
    grant_step(0, 1'b0, 32'h0, 0);

    // pready stuck low -> timeout
    set_req(0, 1'b0, 32'h300, 32'h0, 4'h0);
    grant_step(1000, 1'b0, 32'h0, 0);

    // slave error on a write
    set_req(1, 1'b1, 32'h400, 32'h55, 4'h1);
    grant_step(0, 1'b1, 32'h0, 0);
    grant_step(0, 1'b0, 32'h0, 0);

    // reset during wait states abandons the transfer
    set_req(1, 1'b0, 32'h500, 32'h0, 4'h0);
    tick();
    chk("mr_setup", {30'd0, psel, penable}, 32'd2);
    pready = 1'b0;
    tick();
    tick();
    chk("mr_access", {30'd0, psel, penable}, 32'd3);
    preset_n = 1'b0;
    #1;
    chk("mr_bus_off", {30'd0, psel, penable}, 32'd0);
    chk("mr_no_done", 32'(done), 32'd0);
    tick();
    chk("mr_no_done2", 32'(done), 32'd0);
    preset_n = 1'b1;
    last_g = 1;
    mdone = -1;
    set_req(1, 1'b0, 32'h500, 32'h0, 4'h0);
    grant_step(1, 1'b0, 32'hCAFE_0001, 0);

    // random traffic
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 2; i++)
        if (!req[i] && $urandom_range(1, 0) == 1)
          set_req(i, 1'($urandom), $urandom, $urandom, 4'($urandom));
      wt = ($urandom_range(9, 0) == 0) ? 40 : int'($urandom_range(3, 0));
      grant_step(wt, 1'($urandom), $urandom, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum ACCESS cycles allowed with PREADY low (range 1..255).
REQ-002 pclk  input  1  bus clock; all sequential logic on the rising edge.
REQ-003 preset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req[1:0]  input  2  per-requester transfer request; held high until the matching done bit pulses.
REQ-005 req_write[1:0]  input  2  per-requester direction (1 = write).
REQ-006 req0_addr, req1_addr  input  32 each  transfer address.
REQ-007 req0_wdata, req1_wdata  input  32 each  write data.
REQ-008 req0_strb, req1_strb  input  4 each  write strobes.
REQ-009 done[1:0]  output  2  one-cycle completion pulse per requester.
REQ-010 rsp_rdata  output  32  read data, valid while any done bit is high.
REQ-011 rsp_err  output  1  error flag, valid with done; PSLVERR or timeout.
REQ-012 rsp_timeout  output  1  timeout flag, valid with done.
REQ-013 psel, penable, pwrite  output  1 each  APB control.
REQ-014 paddr  output  32; pwdata  output  32; pstrb  output  4  APB address, data and strobes.
REQ-015 prdata  input  32; pready  input  1; pslverr  input  1  APB slave response.

Function
REQ-016 FSM states: IDLE, SETUP, ACCESS; all APB outputs registered.
REQ-017 IDLE: psel=0, penable=0. With any unmasked req high at a rising edge, go to SETUP.
REQ-018 Arbitration occurs only in IDLE; round-robin via a last-grant pointer. On a tie, the requester not granted last wins. After reset, requester 0 wins the first tie.
REQ-019 In IDLE, the requester whose done bit is currently high is masked from arbitration.
REQ-020 On the grant edge, latch the winner's write/addr/wdata/strb into paddr/pwrite/pwdata/pstrb and update the pointer.
REQ-021 Bus signals stay stable from SETUP until the transfer ends; requester inputs are ignored after the grant.
REQ-022 SETUP: psel=1, penable=0; lasts exactly one cycle, then ACCESS.
REQ-023 ACCESS: psel=1, penable=1.
REQ-024 ACCESS with pready=1 sampled: go to IDLE.
  - Assert done[grant] for one cycle.
  - rsp_rdata = prdata (reads) or 0 (writes).
  - rsp_err = pslverr; rsp_timeout = 0.
REQ-025 ACCESS, pready low, TIMEOUT_CYC consecutive cycles: abort to IDLE.
  - psel=0, penable=0.
  - done[grant]=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-026 Wait counter: 8-bit, cleared on entry to ACCESS, increments each ACCESS cycle with pready=0, saturates at TIMEOUT_CYC.
REQ-027 Latency: req rising before edge k in IDLE gives:
  - SETUP in cycle k+1, ACCESS in k+2.
  - With zero wait states, done in k+3.
REQ-028 Minimum one IDLE cycle between transfers; no back-to-back SETUP.
REQ-029 pready and pslverr are ignored outside ACCESS.
REQ-030 Outside transfers, paddr/pwdata/pstrb/pwrite hold their last values.
REQ-031 At most one done bit is ever high.

Reset
REQ-032 preset_n low forces, asynchronously:
  - state = IDLE; psel, penable, pwrite = 0.
  - paddr, pwdata = 0; pstrb = 0.
  - done = 0, rsp_rdata = 0, rsp_err = 0, rsp_timeout = 0.
  - wait counter = 0; last-grant pointer = requester 1.
REQ-033 Reset during SETUP or ACCESS abandons the transfer with no done pulse. After release, pending requests are re-arbitrated from IDLE.

Verification
REQ-034 Single write: req0, addr 0x10, wdata 0xA5, strb 0xF, pready=1 -> psel one cycle before penable, done[0] in cycle k+3, rsp_err=0.
REQ-035 Read with 3 wait states: req1 read, pready low 3 ACCESS cycles, then pready=1, prdata 0x1234 -> done[1] with rsp_rdata=0x00001234; paddr stable throughout.
REQ-036 Simultaneous req0 and req1 held for 4 transfers after reset -> grant order 0,1,0,1; one IDLE cycle between transfers.
REQ-037 Timeout: TIMEOUT_CYC=16, pready stuck 0 -> abort after 16 ACCESS cycles; done pulses with rsp_err=1, rsp_timeout=1; psel=0 next cycle.
REQ-038 Slave error: write with pslverr=1 at pready=1 -> rsp_err=1, rsp_timeout=0.
REQ-039 Reset mid-ACCESS: assert preset_n low during wait states -> psel/penable 0 immediately, no done; after release, the held request restarts at SETUP.
